xadc_drp_reader: RTL and testbench

XADC_DRP_READER -- requirements
Module: xadc_drp_reader

---
 rtl/xadc_pkg.sv | 7 +
 rtl/xadc_drp_reader.sv | 93 +++++++++
 tb/tb_xadc_drp_reader.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/xadc_pkg.sv
// xadc_pkg: shared XADC definitions (DRP address width, reader FSM states, channel constants).
package xadc_pkg;
    localparam int DADDR_W = 7;
    localparam logic [4:0] VAUX0 = 5'h10;
    localparam logic [4:0] VAUX8 = 5'h18;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
endpackage

// File: rtl/xadc_drp_reader.sv
// xadc_drp_reader: reads each XADC conversion result over DRP on end-of-conversion,
// with a one-deep pending slot for EOCs that arrive mid-read and a drdy timeout.
module xadc_drp_reader
    import xadc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               eoc_in,
    input  logic [4:0]         channel_in,
    output logic [DADDR_W-1:0] daddr_out,
    output logic               den_out,
    output logic               dwe_out,
    output logic [15:0]        di_out,
    input  logic [15:0]        do_in,
    input  logic               drdy_in,
    output logic [15:0]        xadc_data,
    output logic               xadc_data_ready,
    output logic [4:0]         channel,
    output logic               drp_timeout,
    output logic               eoc_overrun
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    state_t state, state_next;
    logic [CW-1:0] cnt, cnt_inc;
    logic [4:0] cur_ch, pend_ch, start_ch;
    logic pend_valid, start, accept, expire, got;
    assign dwe_out = 1'b0;
    assign di_out = 16'h0000;
    assign cnt_inc = cnt + CW'(1);
    // A waiting channel is serviced before a fresh EOC, which then takes the slot.
    assign start_ch = pend_valid ? pend_ch : channel_in;
    always_ff @(posedge clk) state <= reset ? IDLE : state_next;
    always_comb begin
        state_next = state;
        start = 1'b0;
        accept = 1'b0;
        expire = 1'b0;
        den_out = 1'b0;
        case (state)
            IDLE: begin
                start = eoc_in || pend_valid;
                state_next = start ? REQ : IDLE;
            end
            REQ: begin
                den_out = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                accept = drdy_in;
                expire = !drdy_in && cnt_inc == CW'(TIMEOUT_CYCLES);
                state_next = (accept || expire) ? IDLE : WAIT;
            end
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_ch <= '0;
            cur_ch <= '0;
            daddr_out <= '0;
            cnt <= '0;
            xadc_data <= '0;
            channel <= '0;
            got <= 1'b0;
            xadc_data_ready <= 1'b0;
            drp_timeout <= 1'b0;
            eoc_overrun <= 1'b0;
        end else begin
            if (start) begin
                cur_ch <= start_ch;
                daddr_out <= DADDR_W'(start_ch);
            end
            if (eoc_in && (state != IDLE || pend_valid)) begin
                pend_valid <= 1'b1;
                pend_ch <= channel_in;
            end else if (start) begin
                pend_valid <= 1'b0;
            end
            cnt <= (state == WAIT) ? cnt_inc : '0;
            if (accept) begin
                xadc_data <= do_in;
                channel <= cur_ch;
            end
            got <= accept;
            xadc_data_ready <= got;
            drp_timeout <= expire;
            eoc_overrun <= eoc_in && state != IDLE && pend_valid;
        end
    end
endmodule

// File: tb/tb_xadc_drp_reader.sv
// tb_xadc_drp_reader: randomized DRP responder with a transaction-level model of
// reader occupancy and the one-deep EOC slot; directed scenarios plus a random soak.
module tb_xadc_drp_reader;
    import xadc_pkg::*;
    localparam int T = 8;
    logic clk = 1'b0, reset = 1'b1, eoc_in = 1'b0, drdy_in = 1'b0;
    logic [4:0] channel_in = '0;
    logic [15:0] do_in = '0;
    logic [6:0] daddr_out;
    logic den_out, dwe_out, xadc_data_ready, drp_timeout, eoc_overrun;
    logic [15:0] di_out, xadc_data;
    logic [4:0] channel;

    xadc_drp_reader #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .eoc_in(eoc_in), .channel_in(channel_in),
        .daddr_out(daddr_out), .den_out(den_out), .dwe_out(dwe_out), .di_out(di_out),
        .do_in(do_in), .drdy_in(drdy_in), .xadc_data(xadc_data),
        .xadc_data_ready(xadc_data_ready), .channel(channel),
        .drp_timeout(drp_timeout), .eoc_overrun(eoc_overrun)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int cyc; logic [15:0] data; logic [6:0] addr;} ev_t;
    ev_t obs_den[$], obs_rdy[$], exp_den[$], exp_rdy[$];
    int obs_tmo[$], obs_ovr[$], exp_tmo[$], exp_ovr[$];
    int pass = 0, total = 0;

    // Event log keyed by the edge count after which each output pulse is visible.
    always @(negedge clk) begin
        ev_t e;
        if (!reset) begin
            if (den_out) begin e.cyc = cyc; e.data = 16'h0; e.addr = daddr_out; obs_den.push_back(e); end
            if (xadc_data_ready) begin e.cyc = cyc; e.data = xadc_data; e.addr = {2'b00, channel}; obs_rdy.push_back(e); end
            if (drp_timeout) obs_tmo.push_back(cyc);
            if (eoc_overrun) obs_ovr.push_back(cyc);
        end
    end

    int free_at = 0, d_min = 1, d_max = T, never_pct = 0, spur_pct = 0;
    bit slot_v = 0, force_en = 0, spur_ffff = 0;
    logic [4:0] slot_ch = '0, hold_ch = '0;
    logic [15:0] force_data = '0, hold_data = '0;
    logic [15:0] resp_data [int];

    task automatic clear_logs();
        if (exp_rdy.size() > 0) begin
            hold_data = exp_rdy[exp_rdy.size()-1].data;
            hold_ch = exp_rdy[exp_rdy.size()-1].addr[4:0];
        end
        obs_den.delete(); obs_rdy.delete(); obs_tmo.delete(); obs_ovr.delete();
        exp_den.delete(); exp_rdy.delete(); exp_tmo.delete(); exp_ovr.delete();
    endtask

    task automatic model_reset();
        free_at = 0;
        slot_v = 0;
        resp_data.delete();
        exp_rdy.delete();
        hold_data = '0;
        hold_ch = '0;
        clear_logs();
    endtask

    // A read begun at edge x: den after x; drdy d cycles after den is sampled at x+d+1,
    // ready shows after x+d+2; no drdy means timeout after x+1+T.
    task automatic start_read(input int x, input logic [4:0] ch);
        int d;
        ev_t e;
        logic [15:0] v;
        v = force_en ? force_data : 16'($urandom);
        d = (int'($urandom_range(99)) < never_pct) ? 0 : int'($urandom_range(d_max, d_min));
        e.cyc = x; e.data = 16'h0; e.addr = {2'b00, ch};
        exp_den.push_back(e);
        if (d == 0) begin
            exp_tmo.push_back(x + 1 + T);
            free_at = x + 2 + T;
        end else begin
            resp_data[x + d + 1] = v;
            e.cyc = x + d + 2; e.data = v;
            exp_rdy.push_back(e);
            free_at = x + d + 2;
        end
    endtask

    task automatic cycle(input bit eoc, input logic [4:0] ch);
        int x;
        bit idle;
        x = cyc + 1;
        idle = x >= free_at;
        eoc_in = eoc;
        channel_in = eoc ? ch : 5'($urandom);
        drdy_in = resp_data.exists(x) || (idle && int'($urandom_range(99)) < spur_pct);
        do_in = resp_data.exists(x) ? resp_data[x] : (spur_ffff ? 16'hFFFF : 16'($urandom));
        if (idle && (slot_v || eoc)) begin
            start_read(x, slot_v ? slot_ch : ch);
            if (slot_v && eoc) slot_ch = ch;
            else if (slot_v) slot_v = 0;
        end else if (!idle && eoc) begin
            if (slot_v) exp_ovr.push_back(x);
            slot_v = 1;
            slot_ch = ch;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        eoc_in = 1'b1;
        drdy_in = 1'b1;
        do_in = 16'hBEEF;
        channel_in = VAUX8;
        repeat (3) @(negedge clk);
        total++; if (den_out !== 1'b0) $display("FAIL reset_den: got %b want 0", den_out); else pass++;
        total++; if (daddr_out !== 7'h0) $display("FAIL reset_daddr: got %h want 00", daddr_out); else pass++;
        total++; if (xadc_data !== 16'h0) $display("FAIL reset_data: got %h want 0000", xadc_data); else pass++;
        total++; if (channel !== 5'h0) $display("FAIL reset_channel: got %h want 00", channel); else pass++;
        total++; if (xadc_data_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", xadc_data_ready); else pass++;
        total++; if (drp_timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", drp_timeout); else pass++;
        total++; if (eoc_overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", eoc_overrun); else pass++;
        total++; if (dwe_out !== 1'b0 || di_out !== 16'h0) $display("FAIL reset_write_tie: got dwe=%b di=%h want 0/0000", dwe_out, di_out); else pass++;
        eoc_in = 1'b0;
        drdy_in = 1'b0;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_single();
        int e0;
        d_min = 2; d_max = 2; never_pct = 0; force_en = 1; force_data = 16'hA5C0;
        e0 = cyc;
        cycle(1'b1, VAUX0);
        repeat (10) cycle(1'b0, 5'h0);
        total++; if (obs_den.size() !== 1) $display("FAIL single_den_count: got %0d want 1", obs_den.size()); else pass++;
        total++; if (obs_den[0].addr !== 7'h10 || obs_den[0].cyc - e0 !== 1) $display("FAIL single_den: got addr=%h at +%0d want 10 at +1", obs_den[0].addr, obs_den[0].cyc - e0); else pass++;
        total++; if (obs_rdy.size() !== 1) $display("FAIL single_ready_count: got %0d want 1", obs_rdy.size()); else pass++;
        total++; if (obs_rdy[0].data !== 16'hA5C0 || obs_rdy[0].addr !== 7'h10) $display("FAIL single_result: got %h ch %h want a5c0 ch 10", obs_rdy[0].data, obs_rdy[0].addr); else pass++;
        total++; if (obs_rdy[0].cyc - e0 !== 5) $display("FAIL single_latency: got %0d want 5", obs_rdy[0].cyc - e0); else pass++;
        total++; if (dwe_out !== 1'b0 || di_out !== 16'h0) $display("FAIL single_write_tie: got dwe=%b di=%h want 0/0000", dwe_out, di_out); else pass++;
        clear_logs();
    endtask

    task automatic test_back_to_back();
        force_en = 0; d_min = 4; d_max = 4;
        cycle(1'b1, VAUX0);
        repeat (2) cycle(1'b0, 5'h0);
        cycle(1'b1, VAUX8);
        repeat (20) cycle(1'b0, 5'h0);
        total++; if (obs_rdy.size() !== 2) $display("FAIL b2b_ready_count: got %0d want 2", obs_rdy.size()); else pass++;
        total++; if (obs_rdy[0].addr !== 7'h10 || obs_rdy[1].addr !== 7'h18) $display("FAIL b2b_order: got %h,%h want 10,18", obs_rdy[0].addr, obs_rdy[1].addr); else pass++;
        total++; if (obs_rdy[1].data !== exp_rdy[1].data) $display("FAIL b2b_data: got %h want %h", obs_rdy[1].data, exp_rdy[1].data); else pass++;
        total++; if (obs_ovr.size() !== 0) $display("FAIL b2b_overrun: got %0d pulses want 0", obs_ovr.size()); else pass++;
        clear_logs();
    endtask

    task automatic test_overrun();
        int e0;
        d_min = 6; d_max = 6;
        e0 = cyc;
        cycle(1'b1, VAUX0);
        cycle(1'b0, 5'h0);
        cycle(1'b1, 5'h11);
        cycle(1'b1, VAUX8);
        repeat (25) cycle(1'b0, 5'h0);
        total++; if (obs_ovr.size() !== 1) $display("FAIL ovr_count: got %0d want 1", obs_ovr.size()); else pass++;
        total++; if (obs_ovr[0] - e0 !== 4) $display("FAIL ovr_time: got +%0d want +4", obs_ovr[0] - e0); else pass++;
        total++; if (obs_rdy.size() !== 2) $display("FAIL ovr_ready_count: got %0d want 2", obs_rdy.size()); else pass++;
        total++; if (obs_rdy[0].addr !== 7'h10 || obs_rdy[1].addr !== 7'h18) $display("FAIL ovr_order: got %h,%h want 10,18", obs_rdy[0].addr, obs_rdy[1].addr); else pass++;
        total++; if (obs_den.size() !== 2) $display("FAIL ovr_den_count: got %0d want 2", obs_den.size()); else pass++;
        clear_logs();
    endtask

    task automatic test_timeout();
        never_pct = 100;
        cycle(1'b1, VAUX0);
        repeat (T + 4) cycle(1'b0, 5'h0);
        total++; if (obs_tmo.size() !== 1) $display("FAIL tmo_count: got %0d want 1", obs_tmo.size()); else pass++;
        total++; if (obs_tmo[0] - obs_den[0].cyc !== T + 1) $display("FAIL tmo_time: got +%0d want +%0d", obs_tmo[0] - obs_den[0].cyc, T + 1); else pass++;
        total++; if (xadc_data !== hold_data || channel !== hold_ch) $display("FAIL tmo_hold: got %h ch %h want %h ch %h", xadc_data, channel, hold_data, hold_ch); else pass++;
        never_pct = 0; d_min = 3; d_max = 3;
        cycle(1'b1, VAUX8);
        repeat (10) cycle(1'b0, 5'h0);
        total++; if (obs_rdy.size() !== 1) $display("FAIL tmo_ready_count: got %0d want 1", obs_rdy.size()); else pass++;
        total++; if (obs_rdy[0].addr !== 7'h18 || obs_rdy[0].data !== exp_rdy[0].data) $display("FAIL tmo_next: got %h ch %h want %h ch 18", obs_rdy[0].data, obs_rdy[0].addr, exp_rdy[0].data); else pass++;
        clear_logs();
    endtask

    task automatic test_reset_mid();
        int e0;
        never_pct = 100;
        cycle(1'b1, VAUX8);
        repeat (3) cycle(1'b0, 5'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        spur_pct = 100;
        repeat (12) cycle(1'b0, 5'h0);
        spur_pct = 0;
        total++; if (obs_rdy.size() !== 0 || obs_tmo.size() !== 0) $display("FAIL rmid_pulses: got rdy=%0d tmo=%0d want 0/0", obs_rdy.size(), obs_tmo.size()); else pass++;
        total++; if (xadc_data !== 16'h0 || channel !== 5'h0 || daddr_out !== 7'h0) $display("FAIL rmid_outputs: got %h ch %h addr %h want zeros", xadc_data, channel, daddr_out); else pass++;
        total++; if (obs_den.size() !== 0) $display("FAIL rmid_den: got %0d strobes want 0", obs_den.size()); else pass++;
        never_pct = 0; d_min = 2; d_max = 2; force_en = 1; force_data = 16'h1234;
        e0 = cyc;
        cycle(1'b1, VAUX0);
        repeat (6) cycle(1'b0, 5'h0);
        force_en = 0;
        total++; if (obs_den.size() !== 1 || obs_den[0].cyc - e0 !== 1) $display("FAIL rmid_idle: got %0d strobes at +%0d want 1 at +1", obs_den.size(), obs_den[0].cyc - e0); else pass++;
        clear_logs();
    endtask

    task automatic test_spurious();
        spur_pct = 100; spur_ffff = 1;
        repeat (6) cycle(1'b0, 5'h0);
        spur_pct = 0; spur_ffff = 0;
        total++; if (obs_rdy.size() !== 0) $display("FAIL spur_ready: got %0d want 0", obs_rdy.size()); else pass++;
        total++; if (xadc_data !== hold_data || channel !== hold_ch) $display("FAIL spur_hold: got %h ch %h want %h ch %h", xadc_data, channel, hold_data, hold_ch); else pass++;
        clear_logs();
    endtask

    task automatic test_random();
        spur_pct = 15; never_pct = 10; d_min = 1; d_max = T; force_en = 0;
        repeat (400) cycle(int'($urandom_range(99)) < 35, 5'($urandom));
        spur_pct = 0;
        repeat (T + 8) cycle(1'b0, 5'h0);
        total++; if (obs_den.size() !== exp_den.size()) $display("FAIL rand_den_count: got %0d want %0d", obs_den.size(), exp_den.size()); else pass++;
        total++; if (obs_rdy.size() !== exp_rdy.size()) $display("FAIL rand_ready_count: got %0d want %0d", obs_rdy.size(), exp_rdy.size()); else pass++;
        total++; if (obs_tmo != exp_tmo) $display("FAIL rand_timeouts: got %0d pulses want %0d", obs_tmo.size(), exp_tmo.size()); else pass++;
        total++; if (obs_ovr != exp_ovr) $display("FAIL rand_overruns: got %0d pulses want %0d", obs_ovr.size(), exp_ovr.size()); else pass++;
        foreach (exp_den[i]) begin
            total++; if (obs_den[i].cyc !== exp_den[i].cyc || obs_den[i].addr !== exp_den[i].addr) $display("FAIL rand_den[%0d]: got %h@%0d want %h@%0d", i, obs_den[i].addr, obs_den[i].cyc, exp_den[i].addr, exp_den[i].cyc); else pass++;
        end
        foreach (exp_rdy[i]) begin
            total++; if (obs_rdy[i].cyc !== exp_rdy[i].cyc || obs_rdy[i].data !== exp_rdy[i].data || obs_rdy[i].addr !== exp_rdy[i].addr) $display("FAIL rand_ready[%0d]: got %h ch %h @%0d want %h ch %h @%0d", i, obs_rdy[i].data, obs_rdy[i].addr, obs_rdy[i].cyc, exp_rdy[i].data, exp_rdy[i].addr, exp_rdy[i].cyc); else pass++;
        end
        clear_logs();
        total++; if (xadc_data !== hold_data || channel !== hold_ch) $display("FAIL rand_hold: got %h ch %h want %h ch %h", xadc_data, channel, hold_data, hold_ch); else pass++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_timeout();
        test_reset_mid();
        test_spurious();
        test_random();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
